// File: rtl/dv_seq_pkg.sv
// Shared definitions for the test sequencer: state encodings, failure codes
// and the limit-compare helper used by every counted state.
package dv_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD  = 3'd0,
    ST_WAIT_ACTIVE = 3'd1,
    ST_RUN         = 3'd2,
    ST_DRAIN       = 3'd3,
    ST_WAIT_DONE   = 3'd4,
    ST_PASS        = 3'd5,
    ST_FAIL        = 3'd6
  } seq_state_t;

  localparam logic [1:0] FC_NONE        = 2'd0;
  localparam logic [1:0] FC_TIMEOUT     = 2'd1;
  localparam logic [1:0] FC_PROTOCOL    = 2'd2;
  localparam logic [1:0] FC_ACTIVE_LOST = 2'd3;

  // True when the edge being evaluated is the limit-th edge counted by cnt
  // (cnt holds the number of edges already seen). A limit of zero or less
  // fires on the very first edge.
  function automatic logic limit_reached(input logic [63:0] cnt, input int limit);
    logic result;
    if (limit <= 0) begin
      result = 1'b1;
    end else begin
      result = ((cnt + 64'd1) >= 64'($unsigned(limit)));
    end
    return result;
  endfunction

endpackage

// File: rtl/dv_seq_chk.sv
// Invariant checker for the sequencer outputs; has no effect on the design.
module dv_seq_chk
  import dv_seq_pkg::*;
(
  input logic       clk,
  input logic       nreset,
  input logic [2:0] state,
  input logic       start,
  input logic       done,
  input logic       pass,
  input logic       fail,
  input logic [1:0] fail_code
);

  a_pass_fail_excl: assert property (@(posedge clk) disable iff (!nreset)
    !(pass && fail));

  a_done_or: assert property (@(posedge clk) disable iff (!nreset)
    done == (pass | fail));

  a_code_only_on_fail: assert property (@(posedge clk) disable iff (!nreset)
    (fail_code != FC_NONE) |-> fail);

  a_start_states: assert property (@(posedge clk) disable iff (!nreset)
    start == ((state == ST_RUN) || (state == ST_DRAIN) || (state == ST_WAIT_DONE)));

endmodule

// File: rtl/dv_seq_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
module dv_seq_cnt #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_r;

  // Count up while enabled, hold at all-ones, clear has priority over counting.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en && (count_r != {CW{1'b1}})) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/dv_test_seq.sv
// Test sequencer: holds the DUT in reset, waits for it to come up, runs the
// stimulus/drain/check phases and latches a sticky PASS or FAIL verdict.
module dv_test_seq
  import dv_seq_pkg::*;
#(
  parameter int RESET_CYCLES   = 20,
  parameter int ACTIVE_TIMEOUT = 200,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT        = 10000,
  parameter int CW             = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          dut_active,
  input  logic          stim_done,
  input  logic          test_done,
  output logic          dut_nreset,
  output logic          start,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    fail_code,
  output logic [2:0]    state,
  output logic [CW-1:0] cycles
);

  seq_state_t    state_r;
  seq_state_t    next_state_s;
  logic [1:0]    next_code_s;
  logic [1:0]    fail_code_r;
  logic          dut_nreset_r;
  logic          start_r;
  logic          done_r;
  logic          pass_r;
  logic          fail_r;
  logic [CW-1:0] cycles_s;
  logic [CW-1:0] state_cnt_s;
  logic          state_chg_s;
  logic          terminal_s;
  logic          live_s;
  logic          watchdog_s;

  // Free-running cycle count since reset release; keeps counting after the verdict.
  dv_seq_cnt #(.CW(CW)) u_cycle_cnt (
    .clk    (clk),
    .nreset (nreset),
    .clr    (1'b0),
    .en     (1'b1),
    .count  (cycles_s)
  );

  // Edges spent in the current state; restarts from zero on every transition.
  dv_seq_cnt #(.CW(CW)) u_state_cnt (
    .clk    (clk),
    .nreset (nreset),
    .clr    (state_chg_s),
    .en     (1'b1),
    .count  (state_cnt_s)
  );

  assign terminal_s  = (state_r == ST_PASS) || (state_r == ST_FAIL);
  assign live_s      = (state_r == ST_RUN) || (state_r == ST_DRAIN) || (state_r == ST_WAIT_DONE);
  // The watchdog fires on the edge that brings the cycle count to TIMEOUT-1.
  assign watchdog_s  = !terminal_s && limit_reached(64'(cycles_s), TIMEOUT - 1);
  assign state_chg_s = (next_state_s != state_r);

  // Next-state and verdict code; watchdog beats lost-active beats PASS beats the rest.
  always_comb begin
    next_state_s = state_r;
    next_code_s  = fail_code_r;
    if (terminal_s) begin
      next_state_s = state_r;
      next_code_s  = fail_code_r;
    end else if (watchdog_s) begin
      next_state_s = ST_FAIL;
      next_code_s  = FC_TIMEOUT;
    end else if (live_s && !dut_active) begin
      next_state_s = ST_FAIL;
      next_code_s  = FC_ACTIVE_LOST;
    end else begin
      next_code_s = FC_NONE;
      case (state_r)
        ST_RESET_HOLD: begin
          if (limit_reached(64'(state_cnt_s), RESET_CYCLES)) begin
            next_state_s = ST_WAIT_ACTIVE;
          end else begin
            next_state_s = ST_RESET_HOLD;
          end
        end
        ST_WAIT_ACTIVE: begin
          if (dut_active) begin
            next_state_s = ST_RUN;
          end else if (limit_reached(64'(state_cnt_s), ACTIVE_TIMEOUT)) begin
            next_state_s = ST_FAIL;
            next_code_s  = FC_TIMEOUT;
          end else begin
            next_state_s = ST_WAIT_ACTIVE;
          end
        end
        ST_RUN: begin
          if (stim_done && test_done) begin
            next_state_s = ST_PASS;
          end else if (test_done) begin
            next_state_s = ST_FAIL;
            next_code_s  = FC_PROTOCOL;
          end else if (stim_done) begin
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (test_done) begin
            next_state_s = ST_PASS;
          end else if (limit_reached(64'(state_cnt_s), DRAIN_CYCLES)) begin
            next_state_s = ST_WAIT_DONE;
          end else begin
            next_state_s = ST_DRAIN;
          end
        end
        ST_WAIT_DONE: begin
          if (test_done) begin
            next_state_s = ST_PASS;
          end else begin
            next_state_s = ST_WAIT_DONE;
          end
        end
        default: begin
          // Unreachable encoding: fail safe rather than resume the sequence.
          next_state_s = ST_FAIL;
          next_code_s  = FC_PROTOCOL;
        end
      endcase
    end
  end

  // State register and Moore outputs, all decoded from the next state so they
  // change together with the state on the same edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r      <= ST_RESET_HOLD;
      dut_nreset_r <= 1'b0;
      start_r      <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_r       <= 1'b0;
      fail_code_r  <= FC_NONE;
    end else begin
      state_r      <= next_state_s;
      dut_nreset_r <= (next_state_s != ST_RESET_HOLD);
      start_r      <= (next_state_s == ST_RUN) || (next_state_s == ST_DRAIN) ||
                      (next_state_s == ST_WAIT_DONE);
      done_r       <= (next_state_s == ST_PASS) || (next_state_s == ST_FAIL);
      pass_r       <= (next_state_s == ST_PASS);
      fail_r       <= (next_state_s == ST_FAIL);
      fail_code_r  <= (next_state_s == ST_FAIL) ? next_code_s : FC_NONE;
    end
  end

  assign state      = state_r;
  assign dut_nreset = dut_nreset_r;
  assign start      = start_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign fail       = fail_r;
  assign fail_code  = fail_code_r;
  assign cycles     = cycles_s;

  dv_seq_chk u_chk (
    .clk       (clk),
    .nreset    (nreset),
    .state     (state),
    .start     (start),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .fail_code (fail_code)
  );

endmodule

// File: tb/tb_dv_test_seq.sv
// Bench for dv_test_seq: a table of scenarios (input event cycles plus the
// expected verdict and timing), a scoreboard queue of expectations, and a
// hand-written mid-run reset sequence.
module tb_dv_test_seq;
  import dv_seq_pkg::*;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          dut_active = 1'b0;
  logic          stim_done = 1'b0;
  logic          test_done = 1'b0;
  logic          dut_nreset;
  logic          start;
  logic          done;
  logic          pass;
  logic          fail;
  logic [1:0]    fail_code;
  logic [2:0]    state;
  logic [CW-1:0] cycles;

  dv_test_seq #(
    .RESET_CYCLES   (20),
    .ACTIVE_TIMEOUT (200),
    .DRAIN_CYCLES   (4),
    .TIMEOUT        (1000),
    .CW             (CW)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .dut_active (dut_active),
    .stim_done  (stim_done),
    .test_done  (test_done),
    .dut_nreset (dut_nreset),
    .start      (start),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .fail_code  (fail_code),
    .state      (state),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  // Event cycles: an input goes high once the cycle count reaches it (0 = never).
  // drop_at pulls dut_active back low. Expectations are cycle numbers as seen
  // on the cycles output once the edge has happened.
  typedef struct {
    string name;
    int    act_at;
    int    drop_at;
    int    stim_at;
    int    test_at;
    int    exp_state;
    int    exp_code;
    int    exp_done;
    int    exp_first_start;
    int    exp_last_start;
    int    exp_wait_done;
    int    exp_pre;
  } vec_t;

  vec_t tab[11];
  vec_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tb_cyc  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int cyc);
    dut_active = (v.act_at != 0 && cyc >= v.act_at) && !(v.drop_at != 0 && cyc >= v.drop_at);
    stim_done  = (v.stim_at != 0 && cyc >= v.stim_at);
    test_done  = (v.test_at != 0 && cyc >= v.test_at);
  endtask

  // Assert reset between clock edges, check the asynchronous clear, release on a negedge.
  task automatic reset_dut(input string tag);
    nreset = 1'b0;
    dut_active = 1'b0;
    stim_done = 1'b0;
    test_done = 1'b0;
    #1;
    chk({tag, ":reset_outs"}, {state, dut_nreset, start, done, pass, fail, fail_code}, 0);
    chk({tag, ":reset_cycles"}, cycles, 0);
    @(negedge clk);
    nreset = 1'b1;
    tb_cyc = 0;
  endtask

  task automatic run_one(input vec_t v);
    vec_t e;
    int first_s = 0;
    int last_s = 0;
    int wd = 0;
    int nr = 0;
    int pre = 0;
    int got = 0;
    sb_q.push_back(v);
    reset_dut(v.name);
    drive(v, 0);
    for (int k = 0; k < 1100 && got == 0; k++) begin
      @(posedge clk);
      #1;
      tb_cyc++;
      if (start) begin
        if (first_s == 0) first_s = tb_cyc;
        last_s = tb_cyc;
      end
      if (dut_nreset && nr == 0) nr = tb_cyc;
      if (state == ST_WAIT_DONE && wd == 0) wd = tb_cyc;
      if (done) begin
        got = 1;
        e = sb_q.pop_front();
        chk({e.name, ":state"}, state, e.exp_state);
        chk({e.name, ":fail_code"}, fail_code, e.exp_code);
        chk({e.name, ":pass_fail"}, {pass, fail}, {e.exp_state == 5, e.exp_state == 6});
        chk({e.name, ":done_cycle"}, tb_cyc, e.exp_done);
        chk({e.name, ":cycles_at_done"}, cycles, e.exp_done);
        chk({e.name, ":first_start"}, first_s, e.exp_first_start);
        chk({e.name, ":last_start"}, last_s, e.exp_last_start);
        chk({e.name, ":wait_done_entry"}, wd, e.exp_wait_done);
        chk({e.name, ":pre_state"}, pre, e.exp_pre);
        chk({e.name, ":dut_nreset_rise"}, nr, 20);
      end else begin
        pre = int'(state);
        drive(v, tb_cyc);
      end
    end
    if (got == 0) begin
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s:no_verdict: got done=0 expected done=1 by cycle %0d", e.name, e.exp_done);
    end else begin
      // Terminal state must ignore every input and the cycle count keeps running.
      for (int k = 0; k < 5; k++) begin
        dut_active = ~dut_active;
        stim_done = 1'b1;
        test_done = 1'b1;
        @(posedge clk);
        #1;
      end
      chk({v.name, ":sticky_state"}, {state, fail_code}, {v.exp_state[2:0], v.exp_code[1:0]});
      chk({v.name, ":sticky_outs"}, {done, pass, fail, start, dut_nreset},
          {1'b1, v.exp_state == 5, v.exp_state == 6, 1'b0, 1'b1});
      chk({v.name, ":cycles_run_on"}, cycles, v.exp_done + 5);
    end
  endtask

  // Reset pulsed in the middle of RUN: outputs clear at once, then a full replay.
  task automatic mid_run_reset();
    reset_dut("midrun");
    drive(tab[0], 0);
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      tb_cyc++;
      drive(tab[0], tb_cyc);
    end
    chk("midrun:in_run", {state, start}, {ST_RUN, 1'b1});
    #3;
    nreset = 1'b0;
    #1;
    chk("midrun:async_outs", {state, dut_nreset, start, done, pass, fail, fail_code}, 0);
    chk("midrun:async_cycles", cycles, 0);
    run_one(tab[0]);
  endtask

  initial begin
    //          name          act  drop stim test  st code done  first last  wd  pre
    tab[0]  = '{"nominal",     25,   0, 100, 110,  5, 0,  111,  26, 110, 105, 4};
    tab[1]  = '{"active_to",    0,   0,   0,   0,  6, 1,  220,   0,   0,   0, 1};
    tab[2]  = '{"early_test",  25,   0,   0,  50,  6, 2,   51,  26,  50,   0, 2};
    tab[3]  = '{"watchdog",    25,   0, 100,   0,  6, 1,  999,  26, 998, 105, 4};
    tab[4]  = '{"drop_stim",   25,  60,  60,   0,  6, 3,   61,  26,  60,   0, 2};
    tab[5]  = '{"drain_pass",  25,   0, 100, 102,  5, 0,  103,  26, 102,   0, 3};
    tab[6]  = '{"drop_wait",   25, 107, 100,   0,  6, 3,  108,  26, 107, 105, 4};
    tab[7]  = '{"run_pass",    25,   0,  70,  70,  5, 0,   71,  26,  70,   0, 2};
    tab[8]  = '{"act_late",   218,   0, 300, 300,  5, 0,  301, 219, 300,   0, 2};
    tab[9]  = '{"drop_drain",  25, 102, 100, 102,  6, 3,  103,  26, 102,   0, 3};
    tab[10] = '{"wdog_drop",   25, 998, 100,   0,  6, 1,  999,  26, 998, 105, 4};

    #2;
    chk("por:outs", {state, dut_nreset, start, done, pass, fail, fail_code}, 0);
    chk("por:cycles", cycles, 0);
    for (int i = 0; i < 11; i++) begin
      run_one(tab[i]);
    end
    mid_run_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dv_test_seq.md
DV_TEST_SEQ -- requirements
Module: dv_test_seq

Interface
REQ-001 Parameter RESET_CYCLES, default 20, cycles dut_nreset is held low after nreset deasserts.
REQ-002 Parameter ACTIVE_TIMEOUT, default 200, max cycles in WAIT_ACTIVE before failing.
REQ-003 Parameter DRAIN_CYCLES, default 16, settle cycles after stim_done before waiting for test_done.
REQ-004 Parameter TIMEOUT, default 10000, global watchdog in cycles from nreset deassertion.
REQ-005 Parameter CW, default 32, width of the cycle counter.
REQ-006 clk  input  1  main clock.
REQ-007 nreset  input  1  reset, asynchronous, active-low.
REQ-008 dut_active  input  1  DUT reset sequence complete (clk domain).
REQ-009 stim_done  input  1  stimulus finished (level).
REQ-010 test_done  input  1  checker finished (level).
REQ-011 dut_nreset  output  1  DUT reset, active-low.
REQ-012 start  output  1  start test (level).
REQ-013 done  output  1  test reached a terminal state.
REQ-014 pass  output  1  terminal state is PASS.
REQ-015 fail  output  1  terminal state is FAIL.
REQ-016 fail_code  output  2  0 none, 1 timeout, 2 protocol error, 3 dut_active lost.
REQ-017 state  output  3  current state encoding.
REQ-018 cycles  output  CW  cycles since nreset deassertion, saturating.

Function
REQ-019 States SHALL be RESET_HOLD=0, WAIT_ACTIVE=1, RUN=2, DRAIN=3, WAIT_DONE=4, PASS=5, FAIL=6.
REQ-020 RESET_HOLD: dut_nreset=0; exit to WAIT_ACTIVE after exactly RESET_CYCLES rising edges; dut_nreset registered high on that edge.
REQ-021 WAIT_ACTIVE: dut_active=1 -> RUN; ACTIVE_TIMEOUT cycles in state with no dut_active -> FAIL, fail_code=1.
REQ-022 RUN: stim_done=1 -> DRAIN; test_done=1 with stim_done=0 -> FAIL, fail_code=2; test_done and stim_done together -> PASS.
REQ-023 DRAIN: test_done=1 -> PASS; otherwise after DRAIN_CYCLES cycles in state -> WAIT_DONE.
REQ-024 WAIT_DONE: test_done=1 -> PASS.
REQ-025 dut_active=0 in RUN, DRAIN or WAIT_DONE -> FAIL, fail_code=3, unless a higher-priority event fires that cycle.
REQ-026 Global watchdog: cycles reaching TIMEOUT-1 in any non-terminal state -> FAIL, fail_code=1.
REQ-027 Per-cycle priority: watchdog > dut_active lost > PASS condition > other transitions.
REQ-028 PASS and FAIL are sticky until nreset; all inputs ignored there.
REQ-029 start=1 iff state is RUN, DRAIN or WAIT_DONE; Moore, registered.
REQ-030 done=pass|fail; pass and fail are never both 1; fail_code=0 unless fail=1.
REQ-031 cycles increments every clk edge while nreset=1, saturates at all-ones, and keeps counting in terminal states.
REQ-032 The per-state counter clears on every state change; ACTIVE_TIMEOUT=0 or DRAIN_CYCLES=0 means exit on the first cycle in the state.

Reset
REQ-033 nreset=0 SHALL asynchronously force state=RESET_HOLD, dut_nreset=0, start=0, done=pass=fail=0, fail_code=0, cycles=0 and clear all counters.
REQ-034 An nreset assertion in any state, including mid-RUN, SHALL restart the full sequence on deassertion.
REQ-035 All outputs SHALL be registered and glitch-free; dut_nreset deasserts only synchronously to clk.

Structure
REQ-036 State encodings and fail_code constants SHALL live in a shared package dv_seq_pkg.
REQ-037 Reusable sub-module dv_seq_cnt: a saturating CW-bit counter with synchronous clear and enable, instantiated for cycles and for the per-state counter.
REQ-038 There SHALL be no delays, $finish or waveform dumping in the RTL, so the block stays synthesizable.

Verification
REQ-039 Nominal: RESET_CYCLES=20, dut_active at cycle 25, stim_done at 100, test_done at 110 -> dut_nreset rises after edge 20, start at 26, PASS, fail_code=0.
REQ-040 Active timeout: dut_active tied 0, ACTIVE_TIMEOUT=200 -> FAIL at 200 cycles in WAIT_ACTIVE, fail_code=1, start never 1.
REQ-041 Early test_done in RUN before stim_done -> FAIL, fail_code=2, start drops the next cycle.
REQ-042 Watchdog: TIMEOUT=1000, test_done never asserted -> FAIL at cycles=999, fail_code=1; dut_active drop and stim_done in the same cycle -> fail_code=3.
REQ-043 Drain: DRAIN_CYCLES=4, test_done at 2nd drain cycle -> PASS from DRAIN; with test_done absent, state=WAIT_DONE after 4 cycles.
REQ-044 nreset pulsed mid-RUN -> all outputs return to reset values asynchronously, and the sequence replays identically.
